// File: rtl/spi_regfile_param.sv
// Byte-oriented SPI slave, command FSM and register file, all clocked on SCLK.
// Optional write-protect mask in reg[0] is enabled by defining SPI_WRITE_MASK_EN.
module spi_regfile_param #(
    parameter int         DEPTH      = 66,
    parameter int         ADDR_BYTES = 1,
    parameter int         NUM_FLAGS  = 3,
    parameter logic [7:0] RESET_VAL  = 8'h00
) (
    input  logic                   SCLK,
    input  logic                   RESET,
    input  logic                   SS,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [DEPTH*8-1:0]     all_data_out,
    output logic [NUM_FLAGS-1:0]   flag_out,
    output logic                   addr_err,
    output logic                   data_valid_out,
    output logic                   spi_instruction_done
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INSTR   = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_DATA_WR = 3'd3;
    localparam logic [2:0] ST_DATA_RD = 3'd4;
    localparam logic [2:0] ST_FLAG    = 3'd5;
    localparam logic [2:0] ST_IGNORE  = 3'd6;

    logic [2:0]           state_reg;
    logic [2:0]           bit_cnt_reg;
    logic [6:0]           rx_shift_reg;
    logic [7:0]           tx_shift_reg;
    logic [AW-1:0]        addr_ptr_reg;
    logic [1:0]           addr_cnt_reg;
    logic                 is_read_reg;
    logic                 got_byte_reg;
    logic [7:0]           regs_reg [DEPTH];
    logic [NUM_FLAGS-1:0] flags_reg;
    logic                 addr_err_reg;
    logic                 dv_reg;
    logic                 done_reg;

    logic                 byte_done;
    logic [7:0]           rx_byte;
    logic [AW-1:0]        addr_full;
    logic                 addr_last;
    logic [AW-1:0]        rd_addr;
    logic [7:0]           rd_byte;
    logic                 ptr_in_range;
    logic                 wr_blocked;

    assign byte_done    = !SS && (bit_cnt_reg == 3'd7);
    assign rx_byte      = {rx_shift_reg, MOSI};
    assign addr_full    = (addr_ptr_reg << 8) | AW'(rx_byte);
    assign addr_last    = (addr_cnt_reg == 2'(ADDR_BYTES - 1));
    assign rd_addr      = (state_reg == ST_ADDR) ? addr_full : addr_ptr_reg;
    assign ptr_in_range = ({1'b0, addr_ptr_reg} < DEPTH_W);

`ifdef SPI_WRITE_MASK_EN
    // reg[0] bit j guards the 8-register block starting at 8j; block 0 is never guarded
    assign wr_blocked = (addr_ptr_reg[AW-1:6] == '0) && (addr_ptr_reg[5:3] != 3'd0)
                        && regs_reg[0][addr_ptr_reg[5:3]];
`else
    assign wr_blocked = 1'b0;
`endif

    // Out-of-range addresses match no entry and therefore read as zero
    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            if (rd_addr == AW'(k)) rd_byte = regs_reg[k];
        end
    end

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if ({1'b0, p} < DEPTH_W) return (p == LAST) ? '0 : p + 1'b1;
        return p + 1'b1;
    endfunction

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            tx_shift_reg <= 8'h00;
            addr_ptr_reg <= '0;
            addr_cnt_reg <= 2'd0;
            is_read_reg  <= 1'b0;
            got_byte_reg <= 1'b0;
            flags_reg    <= '0;
            addr_err_reg <= 1'b0;
            dv_reg       <= 1'b0;
            done_reg     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) regs_reg[k] <= RESET_VAL;
        end else begin
            dv_reg   <= 1'b0;
            done_reg <= 1'b0;
            if (SS) begin
                state_reg    <= ST_IDLE;
                bit_cnt_reg  <= 3'd0;
                rx_shift_reg <= 7'd0;
                tx_shift_reg <= 8'h00;
                addr_cnt_reg <= 2'd0;
                got_byte_reg <= 1'b0;
                done_reg     <= got_byte_reg;
            end else begin
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                rx_shift_reg <= rx_byte[6:0];
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                if (state_reg == ST_IDLE) state_reg <= ST_INSTR;
                if (byte_done) begin
                    dv_reg <= 1'b1;
                    case (state_reg)
                        ST_INSTR: begin
                            addr_cnt_reg <= 2'd0;
                            addr_ptr_reg <= '0;
                            case (rx_byte)
                                8'h01: begin state_reg <= ST_ADDR; is_read_reg <= 1'b0; end
                                8'h02: begin state_reg <= ST_ADDR; is_read_reg <= 1'b1; end
                                8'h03: state_reg <= ST_FLAG;
                                8'h04: begin
                                    flags_reg    <= '0;
                                    got_byte_reg <= 1'b1;
                                    state_reg    <= ST_IGNORE;
                                end
                                default: state_reg <= ST_IGNORE;
                            endcase
                        end
                        ST_ADDR: begin
                            got_byte_reg <= 1'b1;
                            addr_ptr_reg <= addr_full;
                            addr_cnt_reg <= addr_cnt_reg + 2'd1;
                            if (addr_last) begin
                                if ({1'b0, addr_full} >= DEPTH_W) addr_err_reg <= 1'b1;
                                if (is_read_reg) begin
                                    // Preload the first read byte so MISO is valid before the next edge
                                    tx_shift_reg <= rd_byte;
                                    addr_ptr_reg <= next_ptr(addr_full);
                                    state_reg    <= ST_DATA_RD;
                                end else begin
                                    state_reg <= ST_DATA_WR;
                                end
                            end
                        end
                        ST_DATA_WR: begin
                            got_byte_reg <= 1'b1;
                            if (ptr_in_range && wr_blocked) addr_err_reg <= 1'b1;
                            if (ptr_in_range && !wr_blocked) begin
                                for (int k = 0; k < DEPTH; k++) begin
                                    if (addr_ptr_reg == AW'(k)) regs_reg[k] <= rx_byte;
                                end
                            end
                            addr_ptr_reg <= next_ptr(addr_ptr_reg);
                        end
                        ST_DATA_RD: begin
                            got_byte_reg <= 1'b1;
                            tx_shift_reg <= rd_byte;
                            addr_ptr_reg <= next_ptr(addr_ptr_reg);
                        end
                        ST_FLAG: begin
                            got_byte_reg <= 1'b1;
                            for (int k = 0; k < NUM_FLAGS; k++) begin
                                if (rx_byte == 8'(k)) flags_reg[k] <= 1'b1;
                            end
                        end
                        default: got_byte_reg <= 1'b1;
                    endcase
                end
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_image
        assign all_data_out[8*gi +: 8] = regs_reg[gi];
    end

    assign MISO                 = tx_shift_reg[7];
    assign flag_out             = flags_reg;
    assign addr_err             = addr_err_reg;
    assign data_valid_out       = dv_reg;
    assign spi_instruction_done = done_reg;
endmodule

// File: tb/tb_spi_regfile_param.sv
// Directed bench for spi_regfile_param in its default configuration
// (DEPTH=66, ADDR_BYTES=1, NUM_FLAGS=3, SPI_WRITE_MASK_EN undefined).
module tb_spi_regfile_param;
    localparam int DEPTH = 66;

    logic                 SCLK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 SS = 1'b1;
    logic                 MOSI = 1'b0;
    logic                 MISO;
    logic [DEPTH*8-1:0]   all_data_out;
    logic [2:0]           flag_out;
    logic                 addr_err;
    logic                 data_valid_out;
    logic                 spi_instruction_done;

    spi_regfile_param dut (
        .SCLK                 (SCLK),
        .RESET                (RESET),
        .SS                   (SS),
        .MOSI                 (MOSI),
        .MISO                 (MISO),
        .all_data_out         (all_data_out),
        .flag_out             (flag_out),
        .addr_err             (addr_err),
        .data_valid_out       (data_valid_out),
        .spi_instruction_done (spi_instruction_done)
    );

    always #5 SCLK = ~SCLK;

    int dv_total   = 0;
    int done_total = 0;
    always @(negedge SCLK) begin
        if (data_valid_out)       dv_total   <= dv_total + 1;
        if (spi_instruction_done) done_total <= done_total + 1;
    end

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_regs [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_image(input string tag);
        logic [DEPTH*8-1:0] img;
        int first_bad;
        for (int k = 0; k < DEPTH; k++) img[8*k +: 8] = exp_regs[k];
        first_bad = -1;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (all_data_out[8*k +: 8] !== img[8*k +: 8]) first_bad = k;
        checks++;
        assert (all_data_out === img) passed++;
        else $error("FAIL %s reg %0d observed=%0h expected=%0h", tag, first_bad,
                    all_data_out[8*first_bad +: 8], img[8*first_bad +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            SS   = 1'b0;
            MOSI = b[i];
            r[i] = MISO;
            @(posedge SCLK); #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            SS   = 1'b0;
            MOSI = b[i];
            @(posedge SCLK); #1;
        end
    endtask

    task automatic end_txn();
        SS   = 1'b1;
        MOSI = 1'b0;
        @(posedge SCLK); #1;
        @(posedge SCLK); #1;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] r2;
        int dv0;
        int dn0;

        for (int k = 0; k < DEPTH; k++) exp_regs[k] = 8'h00;

        // Reset state
        repeat (3) @(posedge SCLK);
        #1;
        check_image("reset_image");
        check("reset_flags", 64'(flag_out), 64'h0);
        check("reset_addr_err", 64'(addr_err), 64'h0);
        check("reset_miso", 64'(MISO), 64'h0);
        check("reset_dv", 64'(data_valid_out), 64'h0);
        check("reset_done", 64'(spi_instruction_done), 64'h0);
        RESET = 1'b0;
        @(posedge SCLK); #1;

        // Single write
        dv0 = dv_total; dn0 = done_total;
        send_byte(8'h01, r); send_byte(8'h04, r); send_byte(8'h5A, r);
        end_txn();
        exp_regs[4] = 8'h5A;
        check("wr_single_reg4", 64'(all_data_out[39:32]), 64'h5A);
        check("wr_single_dv_count", 64'(dv_total - dv0), 64'd3);
        check("wr_single_done_count", 64'(done_total - dn0), 64'd1);
        $display("txn write addr=04 data=5A");

        // Burst write wrapping past DEPTH-1
        send_byte(8'h01, r); send_byte(8'h40, r);
        send_byte(8'h11, r); send_byte(8'h22, r); send_byte(8'h33, r);
        end_txn();
        exp_regs[8'h40] = 8'h11; exp_regs[8'h41] = 8'h22; exp_regs[0] = 8'h33;
        check_image("burst_wrap_image");
        check("burst_wrap_reg0", 64'(all_data_out[7:0]), 64'h33);
        $display("txn burst write addr=40 data=11,22,33");

        // Preload and burst read
        send_byte(8'h01, r); send_byte(8'h02, r); send_byte(8'hA5, r); send_byte(8'h3C, r);
        end_txn();
        exp_regs[2] = 8'hA5; exp_regs[3] = 8'h3C;
        check_image("preload_image");
        send_byte(8'h02, r); send_byte(8'h02, r);
        send_byte(8'h00, r); send_byte(8'h00, r2);
        end_txn();
        check("read_byte0", 64'(r), 64'hA5);
        check("read_byte1", 64'(r2), 64'h3C);
        check("miso_idle", 64'(MISO), 64'h0);
        $display("txn read addr=02 got=%h,%h", r, r2);

        // Out-of-range write and read
        check("addr_err_before_oor", 64'(addr_err), 64'h0);
        send_byte(8'h01, r); send_byte(8'h50, r); send_byte(8'hFF, r);
        end_txn();
        check_image("oor_write_image");
        check("oor_addr_err", 64'(addr_err), 64'h1);
        send_byte(8'h02, r); send_byte(8'h50, r); send_byte(8'h00, r);
        end_txn();
        check("oor_read", 64'(r), 64'h00);
        $display("txn out-of-range addr=50 read=%h", r);

        // Flags set and clear
        send_byte(8'h03, r); send_byte(8'h00, r); send_byte(8'h02, r); send_byte(8'h07, r);
        end_txn();
        check("flags_set", 64'(flag_out), 64'h5);
        dn0 = done_total;
        send_byte(8'h04, r);
        end_txn();
        check("flags_clear", 64'(flag_out), 64'h0);
        check("clr_done_count", 64'(done_total - dn0), 64'd1);
        $display("txn flags set 00,02,07 then clear");

        // Unknown instruction is ignored
        send_byte(8'h55, r); send_byte(8'h04, r); send_byte(8'hEE, r);
        end_txn();
        check_image("ignore_image");
        $display("txn unknown instruction 55");

        // Abort after 5 bits of a data byte, then a clean transaction
        send_byte(8'h01, r); send_byte(8'h10, r); send_bits(8'h77, 5);
        end_txn();
        check_image("abort_no_write");
        send_byte(8'h01, r); send_byte(8'h10, r); send_byte(8'h99, r);
        end_txn();
        exp_regs[16] = 8'h99;
        check_image("after_abort_write");
        $display("txn abort then write addr=10 data=99");

        // Reset in the middle of a burst
        send_byte(8'h01, r); send_byte(8'h20, r); send_byte(8'hAA, r); send_bits(8'hBB, 3);
        RESET = 1'b1;
        @(posedge SCLK); #1;
        for (int k = 0; k < DEPTH; k++) exp_regs[k] = 8'h00;
        check_image("mid_reset_image");
        check("mid_reset_addr_err", 64'(addr_err), 64'h0);
        check("mid_reset_miso", 64'(MISO), 64'h0);
        RESET = 1'b0;
        SS    = 1'b1;
        @(posedge SCLK); #1;
        send_byte(8'h01, r); send_byte(8'h05, r); send_byte(8'hC3, r);
        end_txn();
        exp_regs[5] = 8'hC3;
        check_image("post_reset_write");
        $display("txn reset mid-burst then write addr=05 data=C3");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
